// File: rtl/biriscv_clint_pkg.sv
// Shared register map, CTRL field positions and reset constants for the CLINT.
package biriscv_clint_pkg;

    localparam logic [2:0] REG_MTIME_LO    = 3'd0;
    localparam logic [2:0] REG_MTIME_HI    = 3'd1;
    localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
    localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
    localparam logic [2:0] REG_MSIP        = 3'd4;
    localparam logic [2:0] REG_CTRL        = 3'd5;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_PRESCALE_LSB = 8;
    localparam int CTRL_PRESCALE_W   = 8;

    localparam logic [63:0] MTIME_RST    = 64'h0;
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Word indices 6 and 7 fall inside the 5-bit window but are unmapped.
    function automatic logic reg_mapped(input logic [2:0] idx);
        return idx <= REG_CTRL;
    endfunction

endpackage

// File: rtl/biriscv_sync_ff.sv
// Multi-flop synchronizer for an asynchronous level input; all stages reset to 0.
module biriscv_sync_ff #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sync_d;
    logic [DEPTH-1:0] sync_q;

    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], d_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/biriscv_clint.sv
// Machine timer (mtime/mtimecmp with prescaler), software interrupt bit and
// external interrupt synchronizer behind a one-outstanding valid/ready register port.
module biriscv_clint
    import biriscv_clint_pkg::*;
#(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] PRESCALE_RST = 8'd0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [4:0]  req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_accept_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    input  logic        ext_irq_i,
    output logic        ext_intr_o,
    output logic        timer_intr_o,
    output logic        sw_intr_o
);

    logic [63:0] mtime_d, mtime_q;
    logic [63:0] mtimecmp_d, mtimecmp_q;
    logic [31:0] hi_shadow_d, hi_shadow_q;
    logic [7:0]  prescale_d, prescale_q;
    logic [7:0]  presc_cnt_d, presc_cnt_q;
    logic        en_d, en_q;
    logic        msip_d, msip_q;
    logic        timer_intr_d, timer_intr_q;
    logic        resp_valid_d, resp_valid_q;
    logic [31:0] resp_rdata_d, resp_rdata_q;
    logic        resp_error_d, resp_error_q;

    logic [2:0]  word_idx;
    logic        req_fire;
    logic        tick;
    logic [63:0] mtime_inc;
    logic [31:0] read_data;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^req_addr_i[1:0];
    assign word_idx         = req_addr_i[4:2];
    // Valid/ready: a request transfers on req_valid_i & req_ready_o; a new one may
    // enter in the same cycle the previous response is taken with resp_accept_i.
    assign req_ready_o      = ~resp_valid_q | resp_accept_i;
    assign req_fire         = req_valid_i & req_ready_o;
    assign tick             = en_q & (presc_cnt_q == prescale_q);
    assign mtime_inc        = mtime_q + 64'd1;

    always_comb begin
        read_data = '0;
        case (word_idx)
            REG_MTIME_LO:    read_data = mtime_q[31:0];
            REG_MTIME_HI:    read_data = hi_shadow_q;
            REG_MTIMECMP_LO: read_data = mtimecmp_q[31:0];
            REG_MTIMECMP_HI: read_data = mtimecmp_q[63:32];
            REG_MSIP:        read_data[0] = msip_q;
            REG_CTRL: begin
                read_data[CTRL_EN_BIT] = en_q;
                read_data[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W] = prescale_q;
            end
            default:         read_data = '0;
        endcase
    end

    always_comb begin
        mtimecmp_d   = mtimecmp_q;
        hi_shadow_d  = hi_shadow_q;
        prescale_d   = prescale_q;
        en_d         = en_q;
        msip_d       = msip_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        timer_intr_d = (mtime_q >= mtimecmp_q);

        presc_cnt_d = presc_cnt_q;
        if (en_q) begin
            presc_cnt_d = tick ? 8'd0 : presc_cnt_q + 8'd1;
        end
        // Increment first; a software write then overrides only the half it targets.
        mtime_d = tick ? mtime_inc : mtime_q;

        if (req_fire && req_write_i) begin
            case (word_idx)
                REG_MTIME_LO:    mtime_d[31:0]     = req_wdata_i;
                REG_MTIME_HI:    mtime_d[63:32]    = req_wdata_i;
                REG_MTIMECMP_LO: mtimecmp_d[31:0]  = req_wdata_i;
                REG_MTIMECMP_HI: mtimecmp_d[63:32] = req_wdata_i;
                REG_MSIP:        msip_d            = req_wdata_i[0];
                REG_CTRL: begin
                    en_d        = req_wdata_i[CTRL_EN_BIT];
                    prescale_d  = req_wdata_i[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W];
                    presc_cnt_d = 8'd0;
                end
                default: ;
            endcase
        end

        if (req_fire && !req_write_i && word_idx == REG_MTIME_LO) begin
            hi_shadow_d = mtime_q[63:32];
        end

        if (req_fire) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = req_write_i ? 32'd0 : read_data;
            resp_error_d = ~reg_mapped(word_idx);
        end else if (resp_accept_i) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mtime_q      <= MTIME_RST;
            mtimecmp_q   <= MTIMECMP_RST;
            hi_shadow_q  <= '0;
            prescale_q   <= PRESCALE_RST;
            presc_cnt_q  <= '0;
            en_q         <= 1'b0;
            msip_q       <= 1'b0;
            timer_intr_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            hi_shadow_q  <= hi_shadow_d;
            prescale_q   <= prescale_d;
            presc_cnt_q  <= presc_cnt_d;
            en_q         <= en_d;
            msip_q       <= msip_d;
            timer_intr_q <= timer_intr_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
        end
    end

    biriscv_sync_ff #(
        .DEPTH(SYNC_STAGES)
    ) u_ext_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (ext_irq_i),
        .q_o   (ext_intr_o)
    );

    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_error_o = resp_error_q;
    assign timer_intr_o = timer_intr_q;
    assign sw_intr_o    = msip_q;

endmodule

// File: doc/biriscv_clint.md
# biriscv_clint

Machine-level interrupt source: the 64-bit `mtime`/`mtimecmp` timer, a software-interrupt bit (`msip`) and an external-interrupt synchronizer. It drives the `timer_intr_i` and `ext_intr_i` inputs of the core's CSR file. Software reaches it through a simple valid/ready register port from the SoC interconnect.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flops in the `ext_irq_i` synchronizer (≥2).
- `PRESCALE_RST`, default 0: reset value of `CTRL.prescale`.

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset; synchronous, active-low.
- `req_valid_i` in 1: register request valid.
- `req_ready_o` out 1: request accepted when `req_valid_i & req_ready_o`.
- `req_write_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in 5: byte address; bits [1:0] are ignored.
- `req_wdata_i` in 32: write data.
- `resp_valid_o` out 1: response valid.
- `resp_accept_i` in 1: response consumed.
- `resp_rdata_o` out 32: read data; 0 for writes.
- `resp_error_o` out 1: access to an unmapped address.
- `ext_irq_i` in 1: asynchronous level external interrupt.
- `ext_intr_o` out 1: synchronized external interrupt, connects to `ext_intr_i`.
- `timer_intr_o` out 1: connects to `timer_intr_i`.
- `sw_intr_o` out 1: equals `msip`.

## Operation
Register map (word offsets):
- 0x00 `MTIME_LO`. A read also snapshots `mtime[63:32]` into `hi_shadow`.
- 0x04 `MTIME_HI`. A read returns `hi_shadow`; a write sets `mtime[63:32]`.
- 0x08 `MTIMECMP_LO`.
- 0x0C `MTIMECMP_HI`.
- 0x10 `MSIP`: bit 0 only; other bits read 0.
- 0x14 `CTRL`: bit 0 = `en`, bits [15:8] = `prescale`; other bits read 0.
- Any other address: the write is dropped, a read returns 0, and `resp_error_o=1`.

Timer:
- When `en=1`, `mtime` increments by 1 once every `prescale+1` clocks. The prescale counter counts 0..`prescale` and wraps.
- `mtime` wraps from 2^64−1 to 0. The low-to-high carry is applied in the same cycle.
- When `en=0`, both `mtime` and the prescale counter hold.
- A write to `CTRL` clears the prescale counter.
- A software write to `MTIME_LO` or `MTIME_HI` in the same cycle as an increment: the write wins for the written half. The increment (including any carry) still applies to the other half.

Interrupts:
- `timer_intr_o` is a registered flag of the unsigned compare `mtime >= mtimecmp`, taken on the current register values. Writing `mtimecmp` above `mtime` deasserts it.
- `ext_intr_o` is `ext_irq_i` passed through `SYNC_STAGES` flops.

Handshake:
- There is one outstanding request at most: `req_ready_o = ~resp_valid_o | resp_accept_i`.
- The response is registered. `resp_valid_o` holds until `resp_accept_i`, and `resp_rdata_o`/`resp_error_o` are stable while it is held.

Reset values (`rst_ni=0` at a rising edge):
- `mtime=0`, `mtimecmp=64'hFFFF_FFFF_FFFF_FFFF`, `msip=0`, `en=0`, `prescale=PRESCALE_RST`, `hi_shadow=0`.
- All synchronizer flops 0, `resp_valid_o=0`, `resp_rdata_o=0`, `resp_error_o=0`.
- `timer_intr_o=0`, `sw_intr_o=0`, `ext_intr_o=0`. `req_ready_o=1` after reset.
- Reset mid-transaction drops the pending response.

## Timing
- Request accepted at edge N → `resp_valid_o=1` after edge N; its data reflects the register state before edge N.
- The write takes effect at edge N.
- `mtime`/`mtimecmp` change at edge N → `timer_intr_o` updates at edge N+1.
- `msip` written at edge N → `sw_intr_o` changes at edge N.
- `ext_irq_i` rise → `ext_intr_o` rises after `SYNC_STAGES` edges.
- Back-to-back throughput is one request per cycle when `resp_accept_i` is held high.

## Structure
- Shared package `biriscv_clint_pkg`: address offsets, `CTRL` field positions, reset constants.
- Sub-module `biriscv_sync_ff` (parameterized depth, reset to 0) for the external interrupt synchronizer.
- Top level contains the register file, the 64-bit counter with prescaler, the comparator flop and the response register.

## Test plan
- Reset, then read all registers → `MTIME`=0, `MTIMECMP_HI/LO`=0xFFFFFFFF, `MSIP`=0, `CTRL`=`PRESCALE_RST`<<8; `timer_intr_o`=0; no errors.
- `CTRL`=0x0201 (prescale 2, en) → `mtime` increments every 3 clocks; `CTRL`=0 freezes it.
- `MTIME`=0x0000_0000_FFFF_FFFE, en with prescale 0, `MTIMECMP`=0x1_0000_0001:
  - `timer_intr_o` rises exactly one cycle after `mtime` reaches 0x1_0000_0001.
  - Then write `MTIMECMP_LO`=0xFFFFFFFF → `timer_intr_o` falls the next cycle.
- Snapshot: read `MTIME_LO` at 0xFFFF_FFFF, let it carry, then read `MTIME_HI` → returns the pre-carry value 0.
- Hold `resp_accept_i=0` for 5 cycles after a read → `req_ready_o=0`, response stable. Then read unmapped 0x18 → `resp_error_o=1`, rdata 0.
- `ext_irq_i` pulse, `MSIP` write 1 → `ext_intr_o` delayed by `SYNC_STAGES`; `sw_intr_o`=1. Assert `rst_ni` low mid-response → all outputs return to reset values on the next edge.
